// File: rtl/maxpool_pkg.sv
// Shared defaults and width helpers for the streaming max-pool engine.
package maxpool_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_POOL   = 2;
  localparam int unsigned DEF_IMG_W  = 8;
  localparam int unsigned DEF_IMG_H  = 8;

  localparam int unsigned COL_W  = $clog2(DEF_IMG_W);
  localparam int unsigned ROW_W  = $clog2(DEF_IMG_H);
  localparam int unsigned SLOT_W = $clog2(DEF_IMG_W / DEF_POOL);

  // Counter width that stays at least one bit for degenerate ranges.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/max_cmp.sv
// Two-input maximum; MAXPOOL_SIGNED_EN selects two's-complement compare.
module max_cmp #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] max_o
);

  // Select the larger operand; ties return an identical value either way.
  always_comb begin
`ifdef MAXPOOL_SIGNED_EN
    max_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
`else
    max_o = (a_i > b_i) ? a_i : b_i;
`endif
  end

endmodule

// File: rtl/max_pool_stream.sv
// Streaming KxK non-overlapping max-pool with a one-entry output register.
// Optional MAXPOOL_SIGNED_EN (in max_cmp) switches to signed compares.
module max_pool_stream
  import maxpool_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned POOL   = DEF_POOL,
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int unsigned NSLOT = IMG_W / POOL;
  localparam int unsigned CW    = clog2_min1(IMG_W);
  localparam int unsigned RW    = clog2_min1(IMG_H);
  localparam int unsigned SW    = clog2_min1(NSLOT);
  localparam int unsigned WW    = clog2_min1(POOL);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [WW-1:0]     wc_q, wc_d, wr_q, wr_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [DATA_W-1:0] hacc_q, hacc_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  // Sized to a power of two so the slot index always spans the array.
  logic [DATA_W-1:0] buf_q [2**SW];

  logic [DATA_W-1:0] hmax, vmax, hacc_next, v, buf_rd;
  logic              accept, col_end, row_end, wc_end, wr_end, buf_we;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign col_end   = (col_q == CW'(IMG_W - 1));
  assign row_end   = (row_q == RW'(IMG_H - 1));
  assign wc_end    = (wc_q == WW'(POOL - 1));
  assign wr_end    = (wr_q == WW'(POOL - 1));
  assign buf_rd    = buf_q[slot_q];
  assign hacc_next = (wc_q == '0) ? in_data : hmax;
  assign v         = (wr_q == '0) ? hacc_next : vmax;

  max_cmp #(.DATA_W(DATA_W)) u_hmax (.a_i(hacc_q), .b_i(in_data),   .max_o(hmax));
  max_cmp #(.DATA_W(DATA_W)) u_vmax (.a_i(buf_rd), .b_i(hacc_next), .max_o(vmax));

  // Next-state: position counters, horizontal accumulator, output register.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    wc_d        = wc_q;
    wr_d        = wr_q;
    slot_d      = slot_q;
    hacc_d      = hacc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    buf_we      = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      hacc_d = hacc_next;
      if (wc_end) begin
        wc_d   = '0;
        slot_d = col_end ? '0 : slot_q + SW'(1);
        if (!wr_end) begin
          buf_we = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = v;
          out_last_d  = row_end && col_end;
        end
      end else begin
        wc_d = wc_q + WW'(1);
      end
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
        wr_d  = wr_end ? '0 : wr_q + WW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      wc_q        <= '0;
      wr_q        <= '0;
      slot_q      <= '0;
      hacc_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      wc_q        <= wc_d;
      wr_q        <= wr_d;
      slot_q      <= slot_d;
      hacc_q      <= hacc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Column buffer of partial window maxima; every slot is written before it is read.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[slot_q] <= v;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
